// File: rtl/key_debounce_scheduler.sv
// Four-key debouncer for active-low taps with a round-robin single-slot event output.
// Define KEY_RELEASE_EVT_EN to also report key releases as events.
module key_debounce_scheduler #(
  parameter int unsigned CLK_DIV     = 50_000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tap,
  output logic [3:0] key_level,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [1:0] event_key,
  output logic       event_release,
  output logic       overflow
);

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned KEY_W    = 2;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned PRE_W    = $clog2(CLK_DIV);

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_MS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    HOLD = 2'd2,
    RISE = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;

  state_t              state [NUM_KEYS];
  logic [CNT_W-1:0]    cnt   [NUM_KEYS];

  logic [NUM_KEYS-1:0] press_pend;
  logic [NUM_KEYS-1:0] press_set_c;
  logic [NUM_KEYS-1:0] press_clr_c;
  logic [NUM_KEYS-1:0] key_req_c;
  logic [KEY_W-1:0]    last_grant;
  logic [KEY_W-1:0]    scan_key;
  logic [KEY_W-1:0]    grant_key_c;
  logic                grant_c;
  logic                load_c;
  logic                drop_c;

`ifdef KEY_RELEASE_EVT_EN
  logic [NUM_KEYS-1:0] rel_pend;
  logic [NUM_KEYS-1:0] rel_set_c;
  logic [NUM_KEYS-1:0] rel_clr_c;
  logic                grant_rel_c;
`endif

  // Two-flop synchronizer; idle (released) level is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= tap;
      sync_q2 <= sync_q1;
    end
  end

  // Free-running debounce tick prescaler
  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Per-key debounce FSMs; key_level tracks entry into and exit from HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      key_level <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        case (state[i])
          IDLE: begin
            if (!sync_q2[i]) begin
              state[i] <= FALL;
              cnt[i]   <= '0;
            end
          end
          FALL: begin
            if (sync_q2[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == DB_TARGET) begin
              state[i]     <= HOLD;
              cnt[i]       <= '0;
              key_level[i] <= 1'b1;
            end else if (tick) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          HOLD: begin
            if (sync_q2[i]) begin
              state[i]     <= RISE;
              key_level[i] <= 1'b0;
            end
          end
          RISE: begin
            state[i] <= IDLE;
          end
          default: begin
            state[i]     <= IDLE;
            key_level[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Event sources decoded from FSM transitions
  always_comb begin
    press_set_c = '0;
`ifdef KEY_RELEASE_EVT_EN
    rel_set_c   = '0;
`endif
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      press_set_c[i] = (state[i] == FALL) && !sync_q2[i] && (cnt[i] == DB_TARGET);
`ifdef KEY_RELEASE_EVT_EN
      rel_set_c[i]   = (state[i] == RISE);
`endif
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  assign key_req_c = press_pend | rel_pend;
`else
  assign key_req_c = press_pend;
`endif

  // Round-robin arbiter starting after the last granted key; press wins over release
  always_comb begin
    load_c      = !event_valid || event_ready;
    grant_c     = 1'b0;
    grant_key_c = '0;
    scan_key    = '0;
    press_clr_c = '0;
`ifdef KEY_RELEASE_EVT_EN
    rel_clr_c   = '0;
    grant_rel_c = 1'b0;
`endif
    for (int n = 1; n <= int'(NUM_KEYS); n++) begin
      scan_key = last_grant + KEY_W'(n);
      if (!grant_c && key_req_c[scan_key]) begin
        grant_c     = 1'b1;
        grant_key_c = scan_key;
      end
    end
`ifdef KEY_RELEASE_EVT_EN
    grant_rel_c = !press_pend[grant_key_c];
    if (load_c && grant_c) begin
      press_clr_c[grant_key_c] = !grant_rel_c;
      rel_clr_c[grant_key_c]   = grant_rel_c;
    end
`else
    if (load_c && grant_c) begin
      press_clr_c[grant_key_c] = 1'b1;
    end
`endif
  end

  // A set landing on a still-pending bit that is not being granted is dropped
`ifdef KEY_RELEASE_EVT_EN
  assign drop_c = |(press_set_c & press_pend & ~press_clr_c) |
                  |(rel_set_c & rel_pend & ~rel_clr_c);
`else
  assign drop_c = |(press_set_c & press_pend & ~press_clr_c);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_pend <= '0;
      overflow   <= 1'b0;
    end else begin
      press_pend <= (press_pend & ~press_clr_c) | press_set_c;
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_pend <= '0;
    end else begin
      rel_pend <= (rel_pend & ~rel_clr_c) | rel_set_c;
    end
  end
`endif

  // Output slot: reloads when empty or when the held event is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_valid <= 1'b0;
      event_key   <= '0;
      last_grant  <= KEY_W'(NUM_KEYS - 1);
    end else if (load_c) begin
      event_valid <= grant_c;
      if (grant_c) begin
        event_key  <= grant_key_c;
        last_grant <= grant_key_c;
      end
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_release <= 1'b0;
    end else if (load_c && grant_c) begin
      event_release <= grant_rel_c;
    end
  end
`else
  assign event_release = 1'b0;
`endif

endmodule
